// File: rtl/imem_program_encoder.sv
// Packs instruction fields into 32-bit core words, queues them in a FIFO and
// burst-writes them into instruction memory starting at BASE_ADDR.
module imem_program_encoder #(
    parameter int unsigned          DEPTH     = 8,
    parameter int unsigned          ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_imm24,
    input  logic              in_last,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_stall,
    output logic              busy,
    output logic              done,
    output logic              err_op,
    output logic              addr_wrap,
    output logic [ADDR_W:0]   wr_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [32:0]         mem_q [DEPTH];
    logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic                err_op_q, addr_wrap_q;
    logic [31:0]         enc_word;
    logic                enc_err;
    logic                full, empty, push, pop;
    logic [32:0]         head;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign push  = in_valid && in_ready;
    assign pop   = (state_q == WRITE) && !empty;

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (in_op)
            2'b00, 2'b01: enc_word = {in_cond, in_op, in_funct, in_rn, in_rd, in_src2};
            2'b10:        enc_word = {in_cond, 2'b10, in_funct[5:4], in_imm24};
            default:      enc_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE:   if (pop && head[32]) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = !full && reset;
        imem_we    = pop;
        imem_addr  = addr_q;
        imem_wdata = pop ? head[31:0] : '0;
        core_stall = (state_q == WRITE);
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        err_op     = err_op_q;
        addr_wrap  = addr_wrap_q;
        wr_count   = wr_count_q;
    end

    always_comb begin
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        if (state_q == IDLE && start) begin
            addr_d     = BASE_ADDR;
            wr_count_d = '0;
        end else if (pop) begin
            addr_d     = addr_q + ADDR_W'(1);
            wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            wr_count_q  <= '0;
            err_op_q    <= 1'b0;
            addr_wrap_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
                if (enc_err) err_op_q <= 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
                if (addr_q == '1) addr_wrap_q <= 1'b1;
            end
            addr_q     <= addr_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_last, enc_word};
    end

endmodule

// File: tb/tb_imem_program_encoder.sv
// Scoreboard bench: two encoder instances (base 000 and base 3FF); expected
// imem writes are queued at stimulus time and compared by per-instance monitors.
module tb_imem_program_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid_a, valid_b, start_a, start_b, last;
    logic [3:0]  cond, rn, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [11:0] src2;
    logic [23:0] imm24;

    logic        ready_a, we_a, stall_a, busy_a, done_a, err_a, wrap_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] cnt_a;
    logic        ready_b, we_b, stall_b, busy_b, done_b, err_b, wrap_b;
    logic [9:0]  addr_b;
    logic [31:0] wdata_b;
    logic [10:0] cnt_b;

    imem_program_encoder #(.DEPTH(8), .ADDR_W(10), .BASE_ADDR(10'h000)) dut_a (
        .clk(clk), .reset(reset), .in_valid(valid_a), .in_ready(ready_a),
        .in_cond(cond), .in_op(op), .in_funct(funct), .in_rn(rn), .in_rd(rd),
        .in_src2(src2), .in_imm24(imm24), .in_last(last), .start(start_a),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .core_stall(stall_a), .busy(busy_a), .done(done_a), .err_op(err_a),
        .addr_wrap(wrap_a), .wr_count(cnt_a)
    );

    imem_program_encoder #(.DEPTH(8), .ADDR_W(10), .BASE_ADDR(10'h3FF)) dut_b (
        .clk(clk), .reset(reset), .in_valid(valid_b), .in_ready(ready_b),
        .in_cond(cond), .in_op(op), .in_funct(funct), .in_rn(rn), .in_rd(rd),
        .in_src2(src2), .in_imm24(imm24), .in_last(last), .start(start_b),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .core_stall(stall_b), .busy(busy_b), .done(done_b), .err_op(err_b),
        .addr_wrap(wrap_b), .wr_count(cnt_b)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (we_a === 1'b1) begin
            if (qa.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_a: unexpected write addr %0h data %0h, none expected", addr_a, wdata_a);
            end else begin
                e = qa.pop_front();
                check("wr_a_addr", {22'd0, addr_a}, {22'd0, e.addr});
                check("wr_a_data", wdata_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (we_b === 1'b1) begin
            if (qb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr_b: unexpected write addr %0h data %0h, none expected", addr_b, wdata_b);
            end else begin
                e = qb.pop_front();
                check("wr_b_addr", {22'd0, addr_b}, {22'd0, e.addr});
                check("wr_b_data", wdata_b, e.data);
            end
        end
    end

    task automatic set_fields(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                              input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                              input logic [23:0] im, input logic l);
        cond = c; op = o; funct = f; rn = n; rd = d; src2 = s; imm24 = im; last = l;
    endtask

    task automatic wait_ready(input bit to_b);
        int n = 0;
        while (((to_b ? ready_b : ready_a) !== 1'b1) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic push(input bit to_b, input logic [3:0] c, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
                        input logic [11:0] s, input logic [23:0] im, input logic l);
        set_fields(c, o, f, n, d, s, im, l);
        if (to_b) valid_b = 1'b1; else valid_a = 1'b1;
        wait_ready(to_b);
        @(posedge clk); #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic pulse_start(input bit to_b);
        if (to_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit to_b, input string name);
        int n = 0;
        while (((to_b ? done_b : done_a) !== 1'b1) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_done"}, {31'd0, to_b ? done_b : done_a}, 32'd1);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, {31'd0, to_b ? done_b : done_a}, 32'd0);
        check({name, "_idle"}, {31'd0, to_b ? busy_b : busy_a}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; valid_a = 1'b0; valid_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        set_fields(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 12'h000, 24'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_we", {31'd0, we_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_stall", {31'd0, stall_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        check("rst_wrap", {31'd0, wrap_b}, 32'd0);
        check("rst_count", {21'd0, cnt_a}, 32'd0);
        reset = 1'b1;
        #1;
        check("rel_ready", {31'd0, ready_a}, 32'd1);

        // 1: data-processing word
        push(0, 4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0, 1'b1);
        qa.push_back('{10'h000, 32'hE281_2005});
        pulse_start(0);
        check("t1_stall", {31'd0, stall_a}, 32'd1);
        wait_done(0, "t1");
        check("t1_count", {21'd0, cnt_a}, 32'd1);

        // 2: branch word, Rn/Rd/src2 ignored
        push(0, 4'hE, 2'b10, 6'b100000, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFE, 1'b1);
        qa.push_back('{10'h000, 32'hEAFF_FFFE});
        pulse_start(0);
        wait_done(0, "t2");

        // 3: fill FIFO in IDLE, ninth word accepted once draining starts
        for (int i = 0; i < 8; i++) begin
            push(0, 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 12'(i), 24'h0, 1'b0);
            qa.push_back('{10'(i), 32'hE000_0000 + 32'(i)});
        end
        check("t3_full_ready", {31'd0, ready_a}, 32'd0);
        set_fields(4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 12'h008, 24'h0, 1'b1);
        valid_a = 1'b1;
        qa.push_back('{10'h008, 32'hE000_0008});
        pulse_start(0);
        wait_ready(0);
        @(posedge clk); #1;
        valid_a = 1'b0;
        wait_done(0, "t3");
        check("t3_count", {21'd0, cnt_a}, 32'd9);

        // 4: illegal op
        push(0, 4'hE, 2'b11, 6'h3F, 4'h1, 4'h2, 12'h345, 24'h123456, 1'b1);
        check("t4_err_set", {31'd0, err_a}, 32'd1);
        qa.push_back('{10'h000, 32'h0000_0000});
        pulse_start(0);
        wait_done(0, "t4");
        check("t4_err_sticky", {31'd0, err_a}, 32'd1);

        // 5: address wrap from 3FF
        push(1, 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 12'h0AB, 24'h0, 1'b0);
        push(1, 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 12'h0CD, 24'h0, 1'b1);
        qb.push_back('{10'h3FF, 32'hE000_00AB});
        qb.push_back('{10'h000, 32'hE000_00CD});
        pulse_start(1);
        wait_done(1, "t5");
        check("t5_wrap", {31'd0, wrap_b}, 32'd1);
        check("t5_count", {21'd0, cnt_b}, 32'd2);
        check("t5_a_nowrap", {31'd0, wrap_a}, 32'd0);

        // 6: reset mid-burst after three writes; the fourth is already on the bus
        for (int i = 0; i < 6; i++) begin
            push(0, 4'hE, 2'b00, 6'h00, 4'h0, 4'h0, 12'h010 + 12'(i), 24'h0, (i == 5));
            qa.push_back('{10'(i), 32'hE000_0010 + 32'(i)});
        end
        pulse_start(0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("t6_ready_in_reset", {31'd0, ready_a}, 32'd0);
        @(posedge clk); #1;
        check("t6_we", {31'd0, we_a}, 32'd0);
        check("t6_busy", {31'd0, busy_a}, 32'd0);
        check("t6_err_cleared", {31'd0, err_a}, 32'd0);
        check("t6_count_cleared", {21'd0, cnt_a}, 32'd0);
        check("t6_flushed_expect", qa.size(), 32'd2);
        qa.delete();
        reset = 1'b1;
        #1;
        check("t6_ready_release", {31'd0, ready_a}, 32'd1);
        // A fresh one-word burst must not see any stale FIFO entry
        push(0, 4'h1, 2'b01, 6'b011001, 4'h3, 4'h4, 12'h056, 24'h0, 1'b1);
        qa.push_back('{10'h000, 32'h1593_4056});
        pulse_start(0);
        wait_done(0, "t6");
        check("t6_count", {21'd0, cnt_a}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("left_a", qa.size(), 32'd0);
        check("left_b", qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
